mipi_raw_unpack_nx: RTL and testbench

Parametrised CSI-2 RAW pixel unpacker. It sits between the D-PHY byte aligner / lane merger and the ISP pixel pipeline. It accepts 1, 2 or 4 lane-merged bytes per beat and emits four pixels per beat in RAW8, RAW10 or RAW12, selectable per line. Internal byte buffering and valid/ready handshakes on both sides let either side stall without data loss.

---
 rtl/mipi_raw_pkg.sv | 31 +++
 rtl/mipi_raw_group_decode.sv | 43 ++++
 rtl/mipi_raw_unpack_nx.sv | 182 ++++++++++++++++++
 tb/tb_mipi_raw_unpack_nx.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mipi_raw_pkg.sv
`default_nettype none
// ============================================================================
// Package  : mipi_raw_pkg
// Brief    : Shared RAW mode encodings, FSM state type and group-size helper
// Revision : 1.0
// ============================================================================
package mipi_raw_pkg;

    localparam int PIX_W = 12;

    localparam logic [1:0] MODE_RAW8  = 2'd0;
    localparam logic [1:0] MODE_RAW10 = 2'd1;
    localparam logic [1:0] MODE_RAW12 = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DRAIN  = 2'd2
    } unpack_state_t;

    // Bytes consumed per four-pixel group; the reserved code falls back to RAW8.
    function automatic logic [2:0] group_size(input logic [1:0] mode);
        case (mode)
            MODE_RAW10: return 3'd5;
            MODE_RAW12: return 3'd6;
            default:    return 3'd4;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mipi_raw_group_decode.sv
`default_nettype none
// ============================================================================
// Module   : mipi_raw_group_decode
// Brief    : Combinational decode of one packed RAW group into 4 MSB-justified pixels
// Revision : 1.0
// ============================================================================
module mipi_raw_group_decode
    import mipi_raw_pkg::*;
(
    input  logic [47:0] bytes_i,
    input  logic [1:0]  mode_i,
    output logic [47:0] pix_o
);

    logic [7:0] b [6];

    always_comb begin
        for (int i = 0; i < 6; i++) begin
            b[i] = bytes_i[8*i +: 8];
        end
        pix_o = '0;
        case (mode_i)
            MODE_RAW10: begin
                for (int n = 0; n < 4; n++) begin
                    pix_o[12*n +: 12] = {b[n], b[4][2*n +: 2], 2'b00};
                end
            end
            MODE_RAW12: begin
                pix_o[11:0]  = {b[0], b[2][3:0]};
                pix_o[23:12] = {b[1], b[2][7:4]};
                pix_o[35:24] = {b[3], b[5][3:0]};
                pix_o[47:36] = {b[4], b[5][7:4]};
            end
            default: begin
                for (int n = 0; n < 4; n++) begin
                    pix_o[12*n +: 12] = {b[n], 4'h0};
                end
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mipi_raw_unpack_nx.sv
`default_nettype none
// ============================================================================
// Module   : mipi_raw_unpack_nx
// Brief    : CSI-2 RAW8/10/12 unpacker, 1/2/4 merged bytes in, 4 pixels out
// Revision : 1.0
// ============================================================================
module mipi_raw_unpack_nx #(
    parameter int LANES     = 4,
    parameter int PIX_W     = 12,
    parameter int BUF_BYTES = 16
) (
    input  logic                 clk_i,
    input  logic                 reset,
    input  logic [1:0]           mode_i,
    input  logic [8*LANES-1:0]   byte_data_i,
    input  logic [LANES-1:0]     byte_keep_i,
    input  logic                 byte_last_i,
    input  logic                 byte_valid_i,
    output logic                 byte_ready_o,
    output logic [4*PIX_W-1:0]   pix_data_o,
    output logic                 pix_last_o,
    output logic                 pix_valid_o,
    input  logic                 pix_ready_i,
    output logic                 err_residual_o,
    output logic [15:0]          line_groups_o
);
    import mipi_raw_pkg::*;

    localparam int FW = $clog2(BUF_BYTES + LANES + 1);
    localparam int CW = BUF_BYTES + LANES + 6;

    unpack_state_t      state_q, state_d;
    logic [1:0]         mode_q, mode_d, eff_mode;
    logic [FW-1:0]      fill_q, fill_d;
    logic [7:0]         buf_q [BUF_BYTES];
    logic [7:0]         buf_d [BUF_BYTES];
    logic               pix_valid_q, pix_valid_d;
    logic [4*PIX_W-1:0] pix_data_q, pix_data_d;
    logic               pix_last_q, pix_last_d;
    logic               err_q, err_d;
    logic [15:0]        groups_q, groups_d;

    logic [FW-1:0]      grp, room, kcnt, avail, pop_n, rem;
    logic               out_free, pop_head, ready_raw, accept, load, ends_line;
    logic [7:0]         comb_bytes [CW];
    logic [47:0]        head, dec_pix;

    // Ready only looks at the buffer head, keeping it free of any path through the incoming beat.
    always_comb begin
        eff_mode = (state_q == ST_IDLE) ? mode_i : mode_q;
        grp      = FW'(group_size(eff_mode));
        out_free = !pix_valid_q || pix_ready_i;
        pop_head = (fill_q >= grp) && out_free;
        room     = fill_q - (pop_head ? grp : '0) + FW'(LANES);
        case (state_q)
            ST_IDLE:   ready_raw = 1'b1;
            ST_ACTIVE: ready_raw = (room <= FW'(BUF_BYTES));
            default:   ready_raw = 1'b0;
        endcase
    end

    assign byte_ready_o = ready_raw && !reset;
    assign accept       = byte_valid_i && byte_ready_o;

    // Combined view: stored bytes followed by the beat being accepted, so a group
    // completed this cycle reaches the output register on the same edge.
    always_comb begin
        kcnt = '0;
        for (int l = 0; l < LANES; l++) begin
            kcnt = kcnt + FW'(byte_keep_i[l]);
        end
        avail = fill_q + (accept ? kcnt : '0);

        for (int i = 0; i < CW; i++) begin
            comb_bytes[i] = 8'h00;
        end
        for (int i = 0; i < BUF_BYTES; i++) begin
            if (i < int'(fill_q)) comb_bytes[i] = buf_q[i];
        end
        for (int i = 0; i < CW; i++) begin
            for (int l = 0; l < LANES; l++) begin
                if (accept && byte_keep_i[l] && (i == int'(fill_q) + l)) begin
                    comb_bytes[i] = byte_data_i[8*l +: 8];
                end
            end
        end

        load      = out_free && (avail >= grp);
        pop_n     = load ? grp : '0;
        rem       = avail - pop_n;
        ends_line = (state_q == ST_DRAIN) || (accept && byte_last_i);

        for (int i = 0; i < 6; i++) begin
            head[8*i +: 8] = comb_bytes[i];
        end
        for (int i = 0; i < BUF_BYTES; i++) begin
            buf_d[i] = comb_bytes[i];
            for (int k = 4; k <= 6; k++) begin
                if (pop_n == FW'(k)) buf_d[i] = comb_bytes[i + k];
            end
        end
    end

    mipi_raw_group_decode u_decode (
        .bytes_i (head),
        .mode_i  (eff_mode),
        .pix_o   (dec_pix)
    );

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        fill_d      = rem;
        err_d       = 1'b0;
        groups_d    = groups_q;
        pix_valid_d = pix_valid_q;
        pix_data_d  = pix_data_q;
        pix_last_d  = pix_last_q;

        if (pix_valid_q && pix_ready_i && (groups_q != 16'hFFFF)) begin
            groups_d = groups_q + 16'd1;
        end
        if ((state_q == ST_IDLE) && accept) begin
            mode_d   = mode_i;
            groups_d = '0;
            state_d  = ST_ACTIVE;
        end
        // Line end: leave directly once less than a group remains, dropping the residue.
        if (ends_line) begin
            if (rem < grp) begin
                state_d = ST_IDLE;
                fill_d  = '0;
                err_d   = (rem != '0);
            end else begin
                state_d = ST_DRAIN;
            end
        end

        if (load) begin
            pix_valid_d = 1'b1;
            pix_data_d  = dec_pix;
            pix_last_d  = ends_line && (rem < grp);
        end else if (pix_ready_i) begin
            pix_valid_d = 1'b0;
            pix_last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            mode_q      <= MODE_RAW8;
            fill_q      <= '0;
            pix_valid_q <= 1'b0;
            pix_data_q  <= '0;
            pix_last_q  <= 1'b0;
            err_q       <= 1'b0;
            groups_q    <= '0;
            for (int i = 0; i < BUF_BYTES; i++) begin
                buf_q[i] <= 8'h00;
            end
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            fill_q      <= fill_d;
            pix_valid_q <= pix_valid_d;
            pix_data_q  <= pix_data_d;
            pix_last_q  <= pix_last_d;
            err_q       <= err_d;
            groups_q    <= groups_d;
            buf_q       <= buf_d;
        end
    end

    assign pix_valid_o    = pix_valid_q;
    assign pix_data_o     = pix_data_q;
    assign pix_last_o     = pix_last_q;
    assign err_residual_o = err_q;
    assign line_groups_o  = groups_q;

endmodule
`default_nettype wire

// File: tb/tb_mipi_raw_unpack_nx.sv
`default_nettype none
// ============================================================================
// Module   : tb_mipi_raw_unpack_nx
// Brief    : Directed and randomised checks of the RAW unpacker at 4, 2 and 1 lanes
// Revision : 1.0
// ============================================================================
module tb_mipi_raw_unpack_nx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    // 4-lane instance
    logic [1:0]  mode4;
    logic [31:0] d4;
    logic [3:0]  k4;
    logic        l4, v4, rdy4, pl4, pv4, pr4, err4;
    logic [47:0] pd4;
    logic [15:0] lg4;
    // 2-lane instance
    logic [1:0]  mode2;
    logic [15:0] d2;
    logic [1:0]  k2;
    logic        l2, v2, rdy2, pl2, pv2, pr2, err2;
    logic [47:0] pd2;
    logic [15:0] lg2;
    // 1-lane instance
    logic [1:0]  mode1;
    logic [7:0]  d1;
    logic [0:0]  k1;
    logic        l1, v1, rdy1, pl1, pv1, pr1, err1;
    logic [47:0] pd1;
    logic [15:0] lg1;

    logic bp_en;

    mipi_raw_unpack_nx #(.LANES(4), .PIX_W(12), .BUF_BYTES(16)) dut4 (
        .clk_i(clk), .reset(reset), .mode_i(mode4), .byte_data_i(d4), .byte_keep_i(k4),
        .byte_last_i(l4), .byte_valid_i(v4), .byte_ready_o(rdy4), .pix_data_o(pd4),
        .pix_last_o(pl4), .pix_valid_o(pv4), .pix_ready_i(pr4), .err_residual_o(err4),
        .line_groups_o(lg4));

    mipi_raw_unpack_nx #(.LANES(2), .PIX_W(12), .BUF_BYTES(16)) dut2 (
        .clk_i(clk), .reset(reset), .mode_i(mode2), .byte_data_i(d2), .byte_keep_i(k2),
        .byte_last_i(l2), .byte_valid_i(v2), .byte_ready_o(rdy2), .pix_data_o(pd2),
        .pix_last_o(pl2), .pix_valid_o(pv2), .pix_ready_i(pr2), .err_residual_o(err2),
        .line_groups_o(lg2));

    mipi_raw_unpack_nx #(.LANES(1), .PIX_W(12), .BUF_BYTES(16)) dut1 (
        .clk_i(clk), .reset(reset), .mode_i(mode1), .byte_data_i(d1), .byte_keep_i(k1),
        .byte_last_i(l1), .byte_valid_i(v1), .byte_ready_o(rdy1), .pix_data_o(pd1),
        .pix_last_o(pl1), .pix_valid_o(pv1), .pix_ready_i(pr1), .err_residual_o(err1),
        .line_groups_o(lg1));

    logic [48:0] q4[$];
    logic [48:0] q2[$];
    logic [48:0] q1[$];
    int e4 = 0, e2 = 0, e1 = 0;

    // Inputs change on the falling edge; handshakes are observed mid-low-phase.
    always @(negedge clk) begin
        #2;
        if (pv4 && pr4) q4.push_back({pl4, pd4});
        if (pv2 && pr2) q2.push_back({pl2, pd2});
        if (pv1 && pr1) q1.push_back({pl1, pd1});
        if (err4) e4++;
        if (err2) e2++;
        if (err1) e1++;
    end

    always @(negedge clk) begin
        pr1 = bp_en ? ($urandom_range(0, 3) != 0) : 1'b1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic send4(input logic [31:0] d, input logic [3:0] k, input logic l, output int waits);
        v4 = 1'b1; d4 = d; k4 = k; l4 = l; waits = 0;
        #1;
        while (!rdy4 && waits < 200) begin @(negedge clk); #1; waits++; end
        if (!rdy4) check("send4_timeout", 64'(rdy4), 64'(1));
        @(negedge clk);
        v4 = 1'b0;
    endtask

    task automatic send2(input logic [15:0] d, input logic [1:0] k, input logic l, output int waits);
        v2 = 1'b1; d2 = d; k2 = k; l2 = l; waits = 0;
        #1;
        while (!rdy2 && waits < 200) begin @(negedge clk); #1; waits++; end
        if (!rdy2) check("send2_timeout", 64'(rdy2), 64'(1));
        @(negedge clk);
        v2 = 1'b0;
    endtask

    task automatic send1(input logic [7:0] d, input logic l, output int waits);
        v1 = 1'b1; d1 = d; k1 = 1'b1; l1 = l; waits = 0;
        #1;
        while (!rdy1 && waits < 200) begin @(negedge clk); #1; waits++; end
        if (!rdy1) check("send1_timeout", 64'(rdy1), 64'(1));
        @(negedge clk);
        v1 = 1'b0;
    endtask

    // Reference RAW10 group: g[7:0] is B0 ... g[39:32] is B4.
    function automatic logic [47:0] raw10(input logic [39:0] g);
        logic [47:0] p;
        for (int n = 0; n < 4; n++) begin
            p[12*n +: 12] = {g[8*n +: 8], g[32 + 2*n +: 2], 2'b00};
        end
        return p;
    endfunction

    logic [7:0]  rb [5000];
    logic [39:0] gbytes;
    int          w;
    int          e_save;
    int          n_last;

    initial begin
        reset = 1'b1;
        bp_en = 1'b0;
        mode4 = 2'd0; d4 = '0; k4 = '0; l4 = 1'b0; v4 = 1'b0; pr4 = 1'b1;
        mode2 = 2'd0; d2 = '0; k2 = '0; l2 = 1'b0; v2 = 1'b0; pr2 = 1'b1;
        mode1 = 2'd1; d1 = '0; k1 = '0; l1 = 1'b0; v1 = 1'b0;

        // Reset state
        cyc(3);
        check("rst_ready_low", 64'(rdy4), 64'(0));
        check("rst_valid", 64'(pv4), 64'(0));
        check("rst_data", 64'(pd4), 64'(0));
        check("rst_last", 64'(pl4), 64'(0));
        check("rst_err", 64'(err4), 64'(0));
        check("rst_groups", 64'(lg4), 64'(0));
        reset = 1'b0;
        #1;
        check("post_rst_ready", 64'(rdy4), 64'(1));
        @(negedge clk);

        // RAW10, single group
        mode4 = 2'd1;
        send4(32'hD0C0B0A0, 4'hF, 1'b0, w);
        send4(32'h000000E4, 4'h1, 1'b1, w);
        cyc(3);
        check("raw10_count", 64'(q4.size()), 64'(1));
        check("raw10_group", 64'(q4[0]), {15'd0, 1'b1, 48'hD0C_C08_B04_A00});
        check("raw10_groups_o", 64'(lg4), 64'(1));
        check("raw10_no_err", 64'(e4), 64'(0));

        // RAW8 with downstream stall
        q4.delete();
        mode4 = 2'd0;
        pr4   = 1'b0;
        send4(32'h04030201, 4'hF, 1'b0, w);
        check("raw8_beat1_nostall", 64'(w), 64'(0));
        send4(32'h08070605, 4'hF, 1'b1, w);
        check("raw8_beat2_nostall", 64'(w), 64'(0));
        for (int i = 0; i < 5; i++) begin
            #1;
            check("raw8_hold_valid", 64'(pv4), 64'(1));
            check("raw8_hold_data", 64'(pd4), 64'(48'h040_030_020_010));
            check("raw8_hold_last", 64'(pl4), 64'(0));
            @(negedge clk);
        end
        pr4 = 1'b1;
        cyc(3);
        check("raw8_count", 64'(q4.size()), 64'(2));
        check("raw8_group0", 64'(q4[0]), {15'd0, 1'b0, 48'h040_030_020_010});
        check("raw8_group1", 64'(q4[1]), {15'd0, 1'b1, 48'h080_070_060_050});
        check("raw8_groups_o", 64'(lg4), 64'(2));

        // RAW12 at two lanes, mode change mid-line ignored
        mode2 = 2'd2;
        send2(16'h3412, 2'b11, 1'b0, w);
        mode2 = 2'd0;
        send2(16'h7856, 2'b11, 1'b0, w);
        send2(16'hBC9A, 2'b11, 1'b1, w);
        cyc(3);
        check("raw12_count", 64'(q2.size()), 64'(1));
        check("raw12_group", 64'(q2[0]), {15'd0, 1'b1, 48'h9AB_78C_345_126});
        check("raw12_groups_o", 64'(lg2), 64'(1));
        check("raw12_no_err", 64'(e2), 64'(0));

        // RAW10 line with 2-byte residue, then immediate next line
        q4.delete();
        e_save = e4;
        mode4 = 2'd1;
        send4(32'h44332211, 4'hF, 1'b0, w);
        send4(32'h00776655, 4'h7, 1'b1, w);
        mode4 = 2'd0;
        send4(32'hDDCCBBAA, 4'hF, 1'b1, w);
        check("resid_next_line_nostall", 64'(w), 64'(0));
        cyc(3);
        check("resid_count", 64'(q4.size()), 64'(2));
        check("resid_group", 64'(q4[0]), {15'd0, 1'b1, 48'h444_334_224_114});
        check("resid_err_pulses", 64'(e4 - e_save), 64'(1));
        check("resid_next_group", 64'(q4[1]), {15'd0, 1'b1, 48'hDD0_CC0_BB0_AA0});

        // Reset in the middle of a RAW12 line
        q4.delete();
        e_save = e4;
        mode4 = 2'd2;
        pr4   = 1'b0;
        send4(32'h44332211, 4'hF, 1'b0, w);
        send4(32'h88776655, 4'hF, 1'b0, w);
        #1;
        check("midrst_pre_valid", 64'(pv4), 64'(1));
        reset = 1'b1;
        cyc(1);
        check("midrst_ready", 64'(rdy4), 64'(0));
        check("midrst_valid", 64'(pv4), 64'(0));
        check("midrst_data", 64'(pd4), 64'(0));
        check("midrst_last", 64'(pl4), 64'(0));
        check("midrst_groups", 64'(lg4), 64'(0));
        reset = 1'b0;
        pr4   = 1'b1;
        @(negedge clk);
        mode4 = 2'd0;
        send4(32'h04030201, 4'hF, 1'b1, w);
        cyc(3);
        check("midrst_no_err", 64'(e4 - e_save), 64'(0));
        check("midrst_count", 64'(q4.size()), 64'(1));
        check("midrst_raw8_group", 64'(q4[0]), {15'd0, 1'b1, 48'h040_030_020_010});
        check("midrst_groups_o", 64'(lg4), 64'(1));

        // One-lane RAW10 stream, 1000 random groups with random backpressure
        for (int i = 0; i < 5000; i++) rb[i] = 8'($urandom);
        mode1 = 2'd1;
        bp_en = 1'b1;
        for (int i = 0; i < 5000; i++) begin
            send1(rb[i], (i == 4999), w);
        end
        for (int t = 0; t < 3000 && q1.size() < 1000; t++) @(negedge clk);
        bp_en = 1'b0;
        cyc(3);
        check("rand_count", 64'(q1.size()), 64'(1000));
        n_last = 0;
        for (int g = 0; g < 1000 && g < q1.size(); g++) begin
            for (int b = 0; b < 5; b++) gbytes[8*b +: 8] = rb[5*g + b];
            check($sformatf("rand_grp%0d", g), 64'(q1[g][47:0]), 64'(raw10(gbytes)));
            if (q1[g][48]) n_last++;
        end
        check("rand_last_count", 64'(n_last), 64'(1));
        check("rand_final_last", 64'(q1.size() > 0 ? q1[q1.size()-1][48] : 1'b0), 64'(1));
        check("rand_groups_o", 64'(lg1), 64'(1000));
        check("rand_no_err", 64'(e1), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
